// File: rtl/ws_mac_pe_if.sv
// ----------------------------------------------------------------------------
// ws_mac_pe_if
//   Bundles every neighbour-facing link of one weight-stationary MAC PE.
//   The bundle carries three paths:
//     weights     : wt_load, wt_in   -> PE -> wt_out     (vertical shift chain)
//                   wt_latch                            (shadow -> active swap)
//     activations : act_valid_in, act_in -> PE -> act_valid_out, act_out
//     partial sums: psum_valid_in, psum_in -> PE -> psum_valid_out, psum_out,
//                   ovf_out
//   The PE connects to the slave modport. Whatever feeds the PE (neighbours,
//   array edge, or a bench) connects to the master modport.
// ----------------------------------------------------------------------------
interface ws_mac_pe_if #(
  parameter int DATA_W = 8,
  parameter int WT_W   = 8,
  parameter int ACC_W  = 32
);
  logic              wt_load;
  logic [WT_W-1:0]   wt_in;
  logic [WT_W-1:0]   wt_out;
  logic              wt_latch;
  logic              act_valid_in;
  logic [DATA_W-1:0] act_in;
  logic              act_valid_out;
  logic [DATA_W-1:0] act_out;
  logic              psum_valid_in;
  logic [ACC_W-1:0]  psum_in;
  logic              psum_valid_out;
  logic [ACC_W-1:0]  psum_out;
  logic              ovf_out;

  modport slave (
    input  wt_load, wt_in, wt_latch, act_valid_in, act_in, psum_valid_in, psum_in,
    output wt_out, act_valid_out, act_out, psum_valid_out, psum_out, ovf_out
  );

  modport master (
    output wt_load, wt_in, wt_latch, act_valid_in, act_in, psum_valid_in, psum_in,
    input  wt_out, act_valid_out, act_out, psum_valid_out, psum_out, ovf_out
  );
endinterface

// File: rtl/ws_mac_pe.sv
// ----------------------------------------------------------------------------
// ws_mac_pe
//   Weight-stationary systolic MAC cell with double-buffered weights.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset, clears every register
//     pe    : ws_mac_pe_if.slave. It carries the weight chain, the activation
//             path and the partial-sum path. See the interface header.
//   Parameters:
//     DATA_W, WT_W : operand widths
//     ACC_W        : partial-sum width. Must satisfy ACC_W >= DATA_W+WT_W+1.
//     SIGNED       : 1 = two's-complement datapath, 0 = unsigned
//     SATURATE     : 1 = clamp on overflow, 0 = wrap
//   Single-stage datapath: psum_out = psum_in + act_in * active_w, with
//   each addend gated by its valid bit. The result is registered one cycle
//   later.
// ----------------------------------------------------------------------------
module ws_mac_pe #(
  parameter int DATA_W   = 8,
  parameter int WT_W     = 8,
  parameter int ACC_W    = 32,
  parameter bit SIGNED   = 1'b1,
  parameter bit SATURATE = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  ws_mac_pe_if.slave    pe
);

  localparam int PW = DATA_W + WT_W;  // full product width
  localparam int SW = ACC_W + 1;      // sum width, keeps the carry/sign guard bit

  if (ACC_W < DATA_W + WT_W + 1) begin : g_acc_w_check
    $error("ws_mac_pe: ACC_W must be >= DATA_W+WT_W+1");
  end

  logic [WT_W-1:0] shadow_w;
  logic [WT_W-1:0] active_w;

  logic [PW-1:0]    prod;
  logic [SW-1:0]    prod_ext;
  logic [SW-1:0]    psum_ext;
  logic [SW-1:0]    add_a;
  logic [SW-1:0]    add_p;
  logic [SW-1:0]    sum;
  logic             ovf;
  logic [ACC_W-1:0] result;
  logic             any_valid;

  // ---------------- combinational datapath ----------------
  always_comb begin
    // NOTE: every always_comb output is assigned a default first. This keeps
    // later branches from leaving a path unassigned and inferring a latch.
    prod     = '0;
    prod_ext = '0;
    psum_ext = '0;
    ovf      = 1'b0;
    result   = '0;

    if (SIGNED) begin
      prod     = PW'($signed(pe.act_in) * $signed(active_w));
      prod_ext = {{(SW-PW){prod[PW-1]}}, prod};
      psum_ext = {pe.psum_in[ACC_W-1], pe.psum_in};
    end else begin
      prod     = PW'(pe.act_in * active_w);
      prod_ext = {{(SW-PW){1'b0}}, prod};
      psum_ext = {1'b0, pe.psum_in};
    end

    add_a = pe.psum_valid_in ? psum_ext : '0;
    add_p = pe.act_valid_in  ? prod_ext : '0;
    sum   = add_a + add_p;

    // Signed: the addends have the same sign and the ACC_W-bit result does
    // not. Unsigned: a carry into the guard bit.
    if (SIGNED)
      ovf = (add_a[ACC_W-1] == add_p[ACC_W-1]) && (sum[ACC_W-1] != add_a[ACC_W-1]);
    else
      ovf = sum[ACC_W];

    result = sum[ACC_W-1:0];
    if (ovf && SATURATE) begin
      if (!SIGNED)
        result = '1;
      else if (add_a[ACC_W-1])                      // both negative -> min
        result = {1'b1, {(ACC_W-1){1'b0}}};
      else                                          // both positive -> max
        result = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  assign any_valid = pe.act_valid_in | pe.psum_valid_in;
  assign pe.wt_out = shadow_w;

  // ---------------- registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_w          <= '0;
      active_w          <= '0;
      pe.act_out        <= '0;
      pe.act_valid_out  <= 1'b0;
      pe.psum_out       <= '0;
      pe.psum_valid_out <= 1'b0;
      pe.ovf_out        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make active_w take the pre-edge
      // shadow_w, even when wt_load rewrites shadow_w on the same edge.
      if (pe.wt_load)  shadow_w <= pe.wt_in;
      if (pe.wt_latch) active_w <= shadow_w;

      pe.act_out       <= pe.act_in;
      pe.act_valid_out <= pe.act_valid_in;

      pe.psum_valid_out <= any_valid;
      if (any_valid) begin
        pe.psum_out <= result;
        pe.ovf_out  <= ovf;
      end
    end
  end

endmodule

// File: tb/tb_ws_mac_pe.sv
// ----------------------------------------------------------------------------
// tb_ws_mac_pe
//   Four PEs share one stimulus stream:
//     0: ACC_W=32 signed   saturating
//     1: ACC_W=32 unsigned saturating
//     2: ACC_W=17 signed   saturating
//     3: ACC_W=17 signed   wrapping
//   The reference model works on mathematical integers. It adds the operand
//   values, compares the total against the representable range, and clamps
//   or takes the value modulo 2**ACC_W.
// ----------------------------------------------------------------------------
module tb_ws_mac_pe;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // shared stimulus
  logic        wt_load, wt_latch, act_valid_in, psum_valid_in;
  logic [7:0]  wt_in, act_in;
  logic [31:0] psum_in;

  ws_mac_pe_if #(.DATA_W(8), .WT_W(8), .ACC_W(32)) i0 ();
  ws_mac_pe_if #(.DATA_W(8), .WT_W(8), .ACC_W(32)) i1 ();
  ws_mac_pe_if #(.DATA_W(8), .WT_W(8), .ACC_W(17)) i2 ();
  ws_mac_pe_if #(.DATA_W(8), .WT_W(8), .ACC_W(17)) i3 ();

  ws_mac_pe #(.DATA_W(8), .WT_W(8), .ACC_W(32), .SIGNED(1'b1), .SATURATE(1'b1))
    u_s32 (.clk(clk), .rst_n(rst_n), .pe(i0));
  ws_mac_pe #(.DATA_W(8), .WT_W(8), .ACC_W(32), .SIGNED(1'b0), .SATURATE(1'b1))
    u_u32 (.clk(clk), .rst_n(rst_n), .pe(i1));
  ws_mac_pe #(.DATA_W(8), .WT_W(8), .ACC_W(17), .SIGNED(1'b1), .SATURATE(1'b1))
    u_s17 (.clk(clk), .rst_n(rst_n), .pe(i2));
  ws_mac_pe #(.DATA_W(8), .WT_W(8), .ACC_W(17), .SIGNED(1'b1), .SATURATE(1'b0))
    u_w17 (.clk(clk), .rst_n(rst_n), .pe(i3));

  assign i0.wt_load = wt_load;  assign i1.wt_load = wt_load;
  assign i2.wt_load = wt_load;  assign i3.wt_load = wt_load;
  assign i0.wt_in = wt_in;      assign i1.wt_in = wt_in;
  assign i2.wt_in = wt_in;      assign i3.wt_in = wt_in;
  assign i0.wt_latch = wt_latch; assign i1.wt_latch = wt_latch;
  assign i2.wt_latch = wt_latch; assign i3.wt_latch = wt_latch;
  assign i0.act_valid_in = act_valid_in; assign i1.act_valid_in = act_valid_in;
  assign i2.act_valid_in = act_valid_in; assign i3.act_valid_in = act_valid_in;
  assign i0.act_in = act_in;    assign i1.act_in = act_in;
  assign i2.act_in = act_in;    assign i3.act_in = act_in;
  assign i0.psum_valid_in = psum_valid_in; assign i1.psum_valid_in = psum_valid_in;
  assign i2.psum_valid_in = psum_valid_in; assign i3.psum_valid_in = psum_valid_in;
  assign i0.psum_in = psum_in;  assign i1.psum_in = psum_in;
  assign i2.psum_in = psum_in[16:0];
  assign i3.psum_in = psum_in[16:0];

  // observed outputs, gathered for loop-indexed checking
  logic [31:0] got_psum [4];
  logic [7:0]  got_wt   [4];
  logic [7:0]  got_act  [4];
  logic        got_pv   [4];
  logic        got_ovf  [4];
  logic        got_av   [4];

  assign got_psum[0] = i0.psum_out;
  assign got_psum[1] = i1.psum_out;
  assign got_psum[2] = {15'd0, i2.psum_out};
  assign got_psum[3] = {15'd0, i3.psum_out};
  assign got_wt[0] = i0.wt_out;  assign got_wt[1] = i1.wt_out;
  assign got_wt[2] = i2.wt_out;  assign got_wt[3] = i3.wt_out;
  assign got_act[0] = i0.act_out; assign got_act[1] = i1.act_out;
  assign got_act[2] = i2.act_out; assign got_act[3] = i3.act_out;
  assign got_pv[0] = i0.psum_valid_out; assign got_pv[1] = i1.psum_valid_out;
  assign got_pv[2] = i2.psum_valid_out; assign got_pv[3] = i3.psum_valid_out;
  assign got_ovf[0] = i0.ovf_out; assign got_ovf[1] = i1.ovf_out;
  assign got_ovf[2] = i2.ovf_out; assign got_ovf[3] = i3.ovf_out;
  assign got_av[0] = i0.act_valid_out; assign got_av[1] = i1.act_valid_out;
  assign got_av[2] = i2.act_valid_out; assign got_av[3] = i3.act_valid_out;

  // configuration table of the four instances
  int cfg_acc [4] = '{32, 32, 17, 17};
  bit cfg_sgn [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
  bit cfg_sat [4] = '{1'b1, 1'b1, 1'b1, 1'b0};

  // reference model state
  logic [7:0]  m_shadow, m_active;
  logic [31:0] exp_psum [4];
  logic        exp_ovf  [4];
  logic        exp_pv, exp_av;
  logic [7:0]  exp_act;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Result of one MAC for configuration c, computed with integer arithmetic.
  function automatic void model(input int c, output logic [31:0] res, output logic ovf);
    longint modv, a, p, s, maxv, minv;
    modv = longint'(1) << cfg_acc[c];
    a = longint'(psum_in) & (modv - 1);
    if (cfg_sgn[c]) begin
      if (a >= modv / 2) a = a - modv;
      p    = longint'($signed(act_in)) * longint'($signed(m_active));
      maxv = modv / 2 - 1;
      minv = -(modv / 2);
    end else begin
      p    = longint'(act_in) * longint'(m_active);
      maxv = modv - 1;
      minv = 0;
    end
    if (!psum_valid_in) a = 0;
    if (!act_valid_in)  p = 0;
    s   = a + p;
    ovf = (s > maxv) || (s < minv);
    if (ovf && cfg_sat[c]) s = (s > maxv) ? maxv : minv;
    res = 32'(s & (modv - 1));
  endfunction

  function automatic void model_reset();
    m_shadow = '0;
    m_active = '0;
    exp_pv   = 1'b0;
    exp_av   = 1'b0;
    exp_act  = '0;
    for (int c = 0; c < 4; c++) begin
      exp_psum[c] = '0;
      exp_ovf[c]  = 1'b0;
    end
  endfunction

  task automatic check_all(input string tag);
    for (int c = 0; c < 4; c++) begin
      check($sformatf("%s.psum%0d", tag, c), 64'(got_psum[c]), 64'(exp_psum[c]));
      check($sformatf("%s.ovf%0d",  tag, c), 64'(got_ovf[c]),  64'(exp_ovf[c]));
      check($sformatf("%s.pv%0d",   tag, c), 64'(got_pv[c]),   64'(exp_pv));
      check($sformatf("%s.wt%0d",   tag, c), 64'(got_wt[c]),   64'(m_shadow));
      check($sformatf("%s.act%0d",  tag, c), 64'(got_act[c]),  64'(exp_act));
      check($sformatf("%s.av%0d",   tag, c), 64'(got_av[c]),   64'(exp_av));
    end
  endtask

  // Apply the current inputs for one clock, advance the model, and check
  // the outputs 1 time unit after the edge.
  task automatic step(input string tag);
    logic [31:0] r;
    logic        o;
    if (act_valid_in || psum_valid_in) begin
      for (int c = 0; c < 4; c++) begin
        model(c, r, o);
        exp_psum[c] = r;
        exp_ovf[c]  = o;
      end
    end
    exp_pv  = act_valid_in | psum_valid_in;
    exp_av  = act_valid_in;
    exp_act = act_in;
    if (wt_latch) m_active = m_shadow;
    if (wt_load)  m_shadow = wt_in;
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drive(input string tag, input logic ld, input logic [7:0] w,
                       input logic lt, input logic av, input logic [7:0] a,
                       input logic pv, input logic [31:0] p);
    wt_load = ld; wt_in = w; wt_latch = lt;
    act_valid_in = av; act_in = a; psum_valid_in = pv; psum_in = p;
    step(tag);
  endtask

  task automatic idle(input string tag);
    drive(tag, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    wt_load = 0; wt_in = 0; wt_latch = 0;
    act_valid_in = 0; act_in = 0; psum_valid_in = 0; psum_in = 0;
    model_reset();
    #23;
    rst_n = 1'b1;
    @(negedge clk);
    check_all("reset");

    // weight chain: load 5 then 7, then latch and multiply by 3
    drive("ld5", 1, 8'h05, 0, 0, 8'h00, 0, 32'h0);
    check("wt_after_edge1", 64'(got_wt[0]), 64'h05);
    drive("ld7", 1, 8'h07, 0, 0, 8'h00, 0, 32'h0);
    check("wt_after_edge2", 64'(got_wt[0]), 64'h07);
    drive("latch7", 0, 8'h00, 1, 0, 8'h00, 0, 32'h0);
    drive("act3", 0, 8'h00, 0, 1, 8'd3, 0, 32'h0);
    check("psum21", 64'(got_psum[0]), 64'd21);

    // signed MAC: w=-3, act=5, psum=100 -> 85
    drive("ldfd", 1, 8'hFD, 1, 0, 8'h00, 0, 32'h0);
    drive("latchfd", 0, 8'h00, 1, 0, 8'h00, 0, 32'h0);
    drive("mac85", 0, 8'h00, 0, 1, 8'd5, 1, 32'd100);
    check("mac85_s32", 64'(got_psum[0]), 64'd85);
    check("mac85_pv", 64'(got_pv[0]), 64'd1);
    check("mac85_ovf", 64'(got_ovf[0]), 64'd0);

    // top row, extreme operands 0x80 * 0x80
    drive("ld80", 1, 8'h80, 0, 0, 8'h00, 0, 32'h0);
    drive("latch80", 0, 8'h00, 1, 0, 8'h00, 0, 32'h0);
    drive("ext", 0, 8'h00, 0, 1, 8'h80, 0, 32'h0);
    check("ext_signed", 64'(got_psum[0]), 64'd16384);
    check("ext_unsigned", 64'(got_psum[1]), 64'd16384);

    // 17-bit overflow: 65535 + 1*1
    drive("ld1", 1, 8'h01, 0, 0, 8'h00, 0, 32'h0);
    drive("latch1", 0, 8'h00, 1, 0, 8'h00, 0, 32'h0);
    drive("ovf", 0, 8'h00, 0, 1, 8'd1, 1, 32'd65535);
    check("ovf_sat_val", 64'(got_psum[2]), 64'd65535);
    check("ovf_sat_flag", 64'(got_ovf[2]), 64'd1);
    check("ovf_wrap_val", 64'(got_psum[3]), 64'h10000);
    check("ovf_wrap_flag", 64'(got_ovf[3]), 64'd1);
    idle("ovf_hold");
    check("ovf_hold_pv", 64'(got_pv[3]), 64'd0);
    check("ovf_hold_val", 64'(got_psum[3]), 64'h10000);

    // simultaneous latch and compute: shadow=2, active=3
    drive("ld3", 1, 8'h03, 0, 0, 8'h00, 0, 32'h0);
    drive("ld2", 1, 8'h02, 1, 0, 8'h00, 0, 32'h0);
    drive("sim", 1, 8'h09, 1, 1, 8'd10, 0, 32'h0);
    check("sim30", 64'(got_psum[0]), 64'd30);
    drive("sim_next", 0, 8'h00, 0, 1, 8'd10, 0, 32'h0);
    check("sim20", 64'(got_psum[0]), 64'd20);
    check("sim_shadow9", 64'(got_wt[0]), 64'd9);

    // mid-stream asynchronous reset
    drive("ld7b", 1, 8'h07, 0, 0, 8'h00, 0, 32'h0);
    drive("latch7b", 0, 8'h00, 1, 0, 8'h00, 0, 32'h0);
    drive("pass1234", 0, 8'h00, 0, 0, 8'h00, 1, 32'h0000_1234);
    check("pass1234", 64'(got_psum[0]), 64'h1234);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    drive("post_rst", 0, 8'h00, 0, 1, 8'd5, 0, 32'h0);
    check("post_rst_zero", 64'(got_psum[0]), 64'd0);

    // randomized traffic with boundary-biased partial sums
    for (int n = 0; n < 400; n++) begin
      logic [31:0] p;
      case ($urandom_range(0, 4))
        0:       p = 32'h7FFF_FF00 | 32'($urandom_range(0, 255));
        1:       p = 32'h8000_0000 | 32'($urandom_range(0, 255));
        2:       p = 32'h0000_FF00 | 32'($urandom_range(0, 511));
        3:       p = 32'hFFFF_FF00 | 32'($urandom_range(0, 255));
        default: p = $urandom;
      endcase
      drive("rand", ($urandom_range(0, 3) == 0), 8'($urandom),
            ($urandom_range(0, 3) == 0), 1'($urandom), 8'($urandom),
            1'($urandom), p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ws_mac_pe.md
# ws_mac_pe

Parametrised weight-stationary processing element, the next generation of the systolic-array MAC cell. It adds double-buffered weights loaded through a vertical shift chain, valid-qualified activation and partial-sum paths, and a selectable signed or unsigned datapath. The accumulator is wide and saturating, and reports overflow. One instance sits at each (row, column) of the array:

- Activations enter from the left neighbour and leave to the right.
- Weights shift in from above during preload.
- Partial sums enter from above and leave below, toward the accumulator/output buffer.

## Interface
Parameters:
- DATA_W, 8, activation width
- WT_W, 8, weight width
- ACC_W, 32, partial-sum width; legal range ACC_W >= DATA_W+WT_W+1, otherwise elaboration fails
- SIGNED, 1, 1 = two's-complement operands and psum; 0 = unsigned
- SATURATE, 1, 1 = clamp on overflow; 0 = wrap

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- wt_load  in  1  shift-chain enable: shadow weight <= wt_in
- wt_in  in  WT_W  weight from the PE above, or the array edge
- wt_out  out  WT_W  shadow weight register, to the PE below
- wt_latch  in  1  active weight <= shadow weight
- act_valid_in  in  1  act_in qualifier
- act_in  in  DATA_W  activation from the left
- act_valid_out  out  1  registered act_valid_in
- act_out  out  DATA_W  registered act_in, to the right
- psum_valid_in  in  1  psum_in qualifier
- psum_in  in  ACC_W  partial sum from above
- psum_valid_out  out  1  result qualifier
- psum_out  out  ACC_W  registered partial sum, to below
- ovf_out  out  1  overflow occurred in the result currently on psum_out

## Operation
- **Registers:**
  - shadow_w and active_w, both WT_W wide.
  - act_out/act_valid_out.
  - psum_out/psum_valid_out/ovf_out.
  - wt_out is shadow_w directly.
- **Weight path:**
  - wt_load=1: shadow_w <= wt_in. Otherwise shadow_w holds.
  - wt_latch=1: active_w <= shadow_w (pre-edge value).
  - wt_load and wt_latch in the same cycle: active_w takes the old shadow_w while shadow_w takes wt_in.
- **Activation path:**
  - act_out <= act_in and act_valid_out <= act_valid_in every cycle, unconditionally.
  - act_in is forwarded even when invalid.
- **Product:**
  - prod = act_in * active_w, DATA_W+WT_W bits.
  - Sign-extended to ACC_W+1 bits when SIGNED=1, zero-extended when SIGNED=0.
  - The product uses active_w before any same-cycle latch.
- **Sum:**
  - sum = (psum_valid_in ? psum_in : 0) + (act_valid_in ? prod : 0), computed in ACC_W+1 bits.
  - A top-row PE ties psum_valid_in=0, so its psum starts from 0.
- **Overflow:**
  - SIGNED=1: the two addends have the same sign and the ACC_W-bit result sign differs.
  - SIGNED=0: carry out of bit ACC_W-1.
- **Result:**
  - SATURATE=1 with overflow: clamp to the signed max/min in the direction of the operands, or to the unsigned max (all ones).
  - SATURATE=0: keep the low ACC_W bits (wrap).
- **Output update:**
  - When act_valid_in | psum_valid_in: psum_out <= result, ovf_out <= overflow, psum_valid_out <= 1.
  - Otherwise: psum_valid_out <= 0, and psum_out/ovf_out hold their last values.
- **Pass-through:** psum_valid_in=1 with act_valid_in=0 passes psum_in unchanged. This is a bubble-tolerant pass-through; no overflow is possible.

## Timing
- **Reset:** rst_n low immediately clears every register to 0: shadow_w, active_w, wt_out, act_out, act_valid_out, psum_out, psum_valid_out, ovf_out. Reset mid-operation discards in-flight data and loaded weights; no output glitches to non-zero.
- **Latency:**
  - act_in -> act_out: 1 cycle.
  - (act_in, psum_in) -> psum_out: 1 cycle.
  - wt_in -> wt_out: 1 cycle per PE, so an N-deep column loads in N wt_load cycles.
- **Weight swap:** active_w changes on the edge where wt_latch=1. A valid activation on that same cycle multiplies by the old weight; the next cycle uses the new weight. This allows preload of the next tile under compute without stalls.
- **No backpressure:** outputs are valid for exactly the cycle after a qualifying input.
- **Critical path:** multiply + (ACC_W+1)-bit add + clamp, single stage.

## Test plan
- **Reset:** mid-stream, with psum_out=0x0000_1234 and active_w=7, pulse rst_n low -> all outputs 0 asynchronously; after release, act=5 valid produces psum_out=0 (weight cleared).
- **Weight chain:**
  - wt_load with wt_in=0x05, then 0x07 -> wt_out=0x05 after edge 1 and 0x07 after edge 2.
  - wt_latch -> act=3 valid gives psum_out=21.
- **Signed MAC:** active_w=0xFD (-3), act_in=5, psum_in=100 with both valid -> next cycle psum_out=85, psum_valid_out=1, ovf_out=0.
- **Top row, extreme operands:**
  - psum_valid_in=0, act_in=0x80, active_w=0x80, SIGNED=1 -> psum_out=16384.
  - SIGNED=0 -> 16384 as well, since 128*128 = 16384.
- **Overflow, ACC_W=17 SIGNED=1:** psum_in=65535, act=1, w=1 both valid:
  - SATURATE=1 -> 65535, ovf_out=1.
  - SATURATE=0 -> -65536, ovf_out=1.
  - Next idle cycle -> psum_valid_out=0 with values held.
- **Simultaneous latch and compute:** shadow_w=2, active_w=3, act=10 valid with wt_latch=1 and wt_load=1 (wt_in=9) -> psum_out=30. Next act=10 -> 20. shadow_w=9.
